univ_regi: RTL and testbench
============================

# univ_regi

Parametrised universal register, the successor to the plain 32-bit reset register. It adds a configurable width, a configurable reset value and an eight-way mode select: hold, parallel load, shift, rotate and up/down count. Out-of-band bits appear on a single registered carry/shift-out flag. The block serves as the general-purpose state element for datapath and counter duties across the design.

## Interface
- WIDTH, 32, data width in bits (≥2)
- RESET_VAL, 0, value loaded into Q on reset (WIDTH bits)

- En  input  1  clock; all state changes on rising edge
- r  input  1  reset, synchronous, active-low
- D  input  WIDTH  parallel load data
- mode  input  3  operation select (see Operation)
- sin_r  input  1  serial in, enters bit 0 on shift left
- sin_l  input  1  serial in, enters bit WIDTH-1 on shift right
- Q  output  WIDTH  register contents
- co  output  1  registered carry/borrow/shifted-out bit
- zero  output  1  combinational, high when Q == 0

## Operation
- Reset: clock and reset are En and r; reset is synchronous, active-low. On a rising En edge with r=0: Q←RESET_VAL, co←0. Reset overrides every mode.
- With r=1, on each rising En edge, by mode:
  - 000 hold: Q and co unchanged.
  - 001 load: Q←D, co←0.
  - 010 shift left: Q←{Q[WIDTH-2:0], sin_r}, co←Q[WIDTH-1].
  - 011 shift right: Q←{sin_l, Q[WIDTH-1:1]}, co←Q[0].
  - 100 rotate left: Q←{Q[WIDTH-2:0], Q[WIDTH-1]}, co←Q[WIDTH-1].
  - 101 rotate right: Q←{Q[0], Q[WIDTH-1:1]}, co←Q[0].
  - 110 count up: Q←Q+1 modulo 2^WIDTH; co←1 iff the old Q was all ones (wrap), else 0.
  - 111 count down: Q←Q−1 modulo 2^WIDTH; co←1 iff the old Q was 0 (borrow), else 0.
- co always reflects the last non-hold operation. Hold preserves it.
- zero is decoded from Q only, with no dependence on D or mode.
- No X propagation: an X or Z mode is unsupported, and the bench must not drive one.
- All arithmetic is unsigned at exactly WIDTH bits, with no saturation.

## Timing
- Single clock domain, rising edge of En. Latency is 1 cycle from the mode/D/serial inputs to Q and co.
- Inputs are sampled at the edge. Changes between edges have no effect.
- zero follows Q combinationally within the same cycle that Q updates.
- Reset mid-operation: a count or shift in progress is abandoned, Q=RESET_VAL and co=0 after the edge. Operation resumes on the first edge with r=1.
- Reset deasserted with mode≠000 on the same edge: the reset value is loaded first. The mode takes effect from the next edge.
- Values at power-up before the first reset edge are undefined. The bench must apply reset for at least one edge.

## Test plan
- Reset, load and hold: WIDTH=8, RESET_VAL=8'hA5, r=0 for 1 edge, giving Q=A5, co=0, zero=0. Then r=1, mode=001, D=3C, giving Q=3C. Then mode=000 for 3 edges: Q stays 3C and co stays 0.
- Shift and rotate, WIDTH=8, starting from Q=81:
  - Shift left with sin_r=0: Q=02, co=1.
  - Shift right with sin_l=1: Q=81, co=0.
  - Rotate left: Q=03, co=1.
  - Rotate right: Q=81, co=1.
- Count wrap, WIDTH=8:
  - Load FE, then count up: after edge 1, Q=FF, co=0; after edge 2, Q=00, co=1, zero=1; after edge 3, Q=01, co=0.
  - Count down from 01: Q=00, co=0, then Q=FF, co=1.
- Reset mid-count: WIDTH=32, RESET_VAL=0, counting up from 0000_FFFE. Drive r=0 on the edge that would produce 0000_FFFF. Q=0000_0000, co=0, zero=1. Mode stays 110 with r=1, so the next edge gives Q=1.
- Reset versus mode on the same edge: hold mode=001, D=DEADBEEF while r goes 0→1. The first r=1 edge loads DEADBEEF, the preceding r=0 edge gives RESET_VAL, and co=0 throughout.
- Randomised sweep: 200 cycles of random mode/D/sin_l/sin_r/r at WIDTH=32, checked against a behavioural model of every bullet above. Q and co must match every cycle.

Source files
------------

// File: rtl/univ_regi_if.sv
// Bus bundle for univ_regi: control and data towards the register, state and flags back.
//   D      parallel load data
//   mode   operation select
//   sin_r  serial in, enters bit 0 on shift left
//   sin_l  serial in, enters bit WIDTH-1 on shift right
//   Q      register contents
//   co     registered carry/borrow/shifted-out bit
//   zero   combinational Q == 0 flag
interface univ_regi_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] D;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] Q;
  logic             co;
  logic             zero;

  modport master (
    output D, mode, sin_r, sin_l,
    input  Q, co, zero
  );

  modport slave (
    input  D, mode, sin_r, sin_l,
    output Q, co, zero
  );
endinterface

// File: rtl/univ_regi.sv
// Universal register: hold, parallel load, shift, rotate and up/down count,
// with a registered out-of-band bit (carry/borrow/shifted-out) on co.
//   En   clock, all state changes on the rising edge
//   r    synchronous active-low reset, loads RESET_VAL and clears co
//   bus  univ_regi_if slave: D/mode/sin_r/sin_l in, Q/co/zero out
module univ_regi #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic        En,
  input  logic        r,
  univ_regi_if.slave  bus
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;

  // Next-state decode; hold is the default so co survives hold cycles.
  always_comb begin
    q_d  = q_q;
    co_d = co_q;
    case (bus.mode)
      MODE_HOLD: begin
        q_d  = q_q;
        co_d = co_q;
      end
      MODE_LOAD: begin
        q_d  = bus.D;
        co_d = 1'b0;
      end
      MODE_SHL: begin
        q_d  = {q_q[WIDTH-2:0], bus.sin_r};
        co_d = q_q[WIDTH-1];
      end
      MODE_SHR: begin
        q_d  = {bus.sin_l, q_q[WIDTH-1:1]};
        co_d = q_q[0];
      end
      MODE_ROL: begin
        q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        co_d = q_q[WIDTH-1];
      end
      MODE_ROR: begin
        q_d  = {q_q[0], q_q[WIDTH-1:1]};
        co_d = q_q[0];
      end
      // Wrap flag is taken from the old value: all ones rolls over to zero.
      MODE_INC: begin
        q_d  = q_q + WIDTH'(1);
        co_d = &q_q;
      end
      // Borrow flag: only an old value of zero underflows.
      MODE_DEC: begin
        q_d  = q_q - WIDTH'(1);
        co_d = ~|q_q;
      end
      default: begin
        q_d  = q_q;
        co_d = co_q;
      end
    endcase
  end

  // State register; reset wins over any mode on the same edge.
  always_ff @(posedge En) begin
    if (!r) begin
      q_q  <= RESET_VAL;
      co_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.co   = co_q;
  assign bus.zero = ~|q_q;

endmodule

// File: tb/tb_univ_regi.sv
module tb_univ_regi;

  typedef struct {
    logic [31:0] q;
    logic        co;
    string       tag;
  } exp_t;

  logic En;
  logic r8;
  logic r32;

  univ_regi_if #(.WIDTH(8))  if8  ();
  univ_regi_if #(.WIDTH(32)) if32 ();

  univ_regi #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .En  (En),
    .r   (r8),
    .bus (if8.slave)
  );

  univ_regi #(.WIDTH(32), .RESET_VAL(32'h0)) dut32 (
    .En  (En),
    .r   (r32),
    .bus (if32.slave)
  );

  exp_t q8[$];
  exp_t q32[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mq;
  logic        mco;

  initial En = 1'b0;
  always #5 En = ~En;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: one expected entry per clock edge, compared just after the edge.
  always @(posedge En) begin : mon8
    exp_t e;
    #1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk({e.tag, ".Q"},    32'(if8.Q),    32'(e.q[7:0]));
      chk({e.tag, ".co"},   32'(if8.co),   32'(e.co));
      chk({e.tag, ".zero"}, 32'(if8.zero), 32'(e.q[7:0] == 8'h00));
    end
  end

  always @(posedge En) begin : mon32
    exp_t e;
    #1;
    if (q32.size() > 0) begin
      e = q32.pop_front();
      chk({e.tag, ".Q"},    32'(if32.Q),    e.q);
      chk({e.tag, ".co"},   32'(if32.co),   32'(e.co));
      chk({e.tag, ".zero"}, 32'(if32.zero), 32'(e.q == 32'h0));
    end
  end

  task automatic drive8(input logic rr, input logic [2:0] m, input logic [7:0] d,
                        input logic sr, input logic sl,
                        input logic [7:0] eq, input logic eco, input string tag);
    exp_t e;
    @(negedge En);
    r8        = rr;
    if8.mode  = m;
    if8.D     = d;
    if8.sin_r = sr;
    if8.sin_l = sl;
    e.q   = 32'(eq);
    e.co  = eco;
    e.tag = tag;
    q8.push_back(e);
  endtask

  task automatic drive32(input logic rr, input logic [2:0] m, input logic [31:0] d,
                         input logic [31:0] eq, input logic eco, input string tag);
    exp_t e;
    @(negedge En);
    r32        = rr;
    if32.mode  = m;
    if32.D     = d;
    if32.sin_r = 1'b0;
    if32.sin_l = 1'b0;
    e.q   = eq;
    e.co  = eco;
    e.tag = tag;
    q32.push_back(e);
    mq  = eq;
    mco = eco;
  endtask

  // Random step: the expected value comes from a behavioural model of each mode.
  task automatic rand32(input int idx);
    exp_t        e;
    logic        rr;
    logic [2:0]  m;
    logic [31:0] d;
    logic        sr;
    logic        sl;
    logic [32:0] sum;
    rr = ($urandom_range(0, 7) != 0);
    m  = 3'($urandom_range(0, 7));
    d  = $urandom;
    sr = 1'($urandom_range(0, 1));
    sl = 1'($urandom_range(0, 1));
    if (!rr) begin
      mq  = 32'h0;
      mco = 1'b0;
    end else begin
      case (m)
        3'd1: begin mq = d; mco = 1'b0; end
        3'd2: begin mco = mq[31]; mq = (mq << 1) | 32'(sr); end
        3'd3: begin mco = mq[0];  mq = (mq >> 1) | (32'(sl) << 31); end
        3'd4: begin mco = mq[31]; mq = (mq << 1) | (mq >> 31); end
        3'd5: begin mco = mq[0];  mq = (mq >> 1) | (mq << 31); end
        3'd6: begin sum = 33'(mq) + 33'd1; mco = sum[32]; mq = sum[31:0]; end
        3'd7: begin mco = (mq == 32'h0); mq = mq - 32'd1; end
        default: ;
      endcase
    end
    @(negedge En);
    r32        = rr;
    if32.mode  = m;
    if32.D     = d;
    if32.sin_r = sr;
    if32.sin_l = sl;
    e.q   = mq;
    e.co  = mco;
    e.tag = $sformatf("rnd%0d", idx);
    q32.push_back(e);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    r8 = 1'b0; r32 = 1'b0;
    if8.mode = 3'b000;  if8.D = 8'h00;  if8.sin_r = 1'b0;  if8.sin_l = 1'b0;
    if32.mode = 3'b000; if32.D = 32'h0; if32.sin_r = 1'b0; if32.sin_l = 1'b0;
    mq = 32'h0; mco = 1'b0;

    // 8-bit: reset, load, hold
    drive8(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, "rst8");
    drive8(1'b1, 3'b001, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, "load3c");
    for (int i = 0; i < 3; i++)
      drive8(1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 8'h3C, 1'b0, $sformatf("hold%0d", i));
    // shift / rotate from 81
    drive8(1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, "load81");
    drive8(1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, "shl");
    drive8(1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 8'h81, 1'b0, "shr");
    drive8(1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, "rol");
    drive8(1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1, "ror");
    drive8(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1, "hold_co1");
    // count wrap both ways
    drive8(1'b1, 3'b001, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0, "loadfe");
    drive8(1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, "up1");
    drive8(1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, "up_wrap");
    drive8(1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, "up3");
    drive8(1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "dn1");
    drive8(1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, "dn_borrow");
    drive8(1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, "shl_ones");
    drive8(1'b0, 3'b110, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, "rst_mid8");
    drive8(1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h52, 1'b1, "shr_a5");

    // 32-bit: reset mid-count, reset vs mode on same edge, full-width wraps
    drive32(1'b0, 3'b000, 32'h0,        32'h0000_0000, 1'b0, "rst32");
    drive32(1'b1, 3'b001, 32'h0000_FFFE, 32'h0000_FFFE, 1'b0, "loadfffe");
    drive32(1'b0, 3'b110, 32'h0,        32'h0000_0000, 1'b0, "rst_mid");
    drive32(1'b1, 3'b110, 32'h0,        32'h0000_0001, 1'b0, "resume");
    drive32(1'b0, 3'b001, 32'hDEADBEEF, 32'h0000_0000, 1'b0, "rst_vs_load");
    drive32(1'b1, 3'b001, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "first_load");
    drive32(1'b1, 3'b111, 32'h0,        32'hDEADBEEE, 1'b0, "dn32");
    drive32(1'b1, 3'b001, 32'h0,        32'h0000_0000, 1'b0, "load0");
    drive32(1'b1, 3'b111, 32'h0,        32'hFFFF_FFFF, 1'b1, "borrow32");
    drive32(1'b1, 3'b000, 32'h1234,     32'hFFFF_FFFF, 1'b1, "hold32");
    drive32(1'b1, 3'b110, 32'h0,        32'h0000_0000, 1'b1, "wrap32");

    for (int i = 0; i < 200; i++) rand32(i);

    repeat (3) @(negedge En);
    chk("queues_drained", 32'(q8.size() + q32.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
